modbus_tx_framer: RTL and testbench
===================================

Name: modbus_tx_framer

Overview:
- Response-side frame sequencer for the Modbus RTU slave. Sits downstream of the response CRC stage and upstream of the UART byte transmitter.
- On request it latches function code and quantity, presents them to the CRC stage, and pulses crc_start. It then waits for crc_done.
- It then streams the full RTU response byte by byte over a valid/ready handshake: address, function, quantity, data words (high byte first), CRC low, CRC high.

Parameters:
- SADDR, 8'h01, slave address; first byte of every frame and identical to the CRC stage's SADDR.
- MAX_QTY, 8'd125, largest accepted register quantity.
- CRC_TIMEOUT, 16'd4096, cycles allowed between crc_start and crc_done before abort.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous reset, active high
- tx_start  input  1  one-cycle request to send a response
- func_code  input  8  function code, sampled on accepted tx_start
- tx_quantity  input  8  register count Q, sampled on accepted tx_start
- crc_func_code  output  8  latched function code, to CRC stage
- crc_quantity  output  8  latched Q, to CRC stage
- crc_start  output  1  one-cycle pulse to CRC stage
- crc_calc  input  16  CRC result from CRC stage
- crc_done  input  1  one-cycle CRC completion strobe
- rd_addr  output  8  register word index, to register file read port
- rd_data  input  16  register word; valid 1 cycle after rd_addr changes
- tx_byte  output  8  byte to UART transmitter
- tx_byte_valid  output  1  tx_byte is valid
- tx_byte_ready  input  1  UART accepts byte this cycle
- busy  output  1  high in every state except IDLE
- tx_done  output  1  one-cycle pulse after last byte accepted
- tx_err  output  1  one-cycle pulse on abort

Behaviour:
- Reset (async, rst_in=1): state IDLE. All outputs 0: crc_func_code, crc_quantity, crc_start, rd_addr, tx_byte, tx_byte_valid, busy, tx_done, tx_err. Internal counters and latched CRC also 0. Reset mid-frame drops tx_byte_valid immediately; no partial-frame completion.
- States: IDLE, CRC_REQ, CRC_WAIT, FETCH, SEND, DONE, ERR.
- IDLE:
  - tx_start=1 latches func_code and Q into crc_func_code/crc_quantity.
  - If Q > MAX_QTY, go to ERR; no crc_start is issued.
  - Otherwise go to CRC_REQ.
- CRC_REQ: crc_start=1 for exactly one cycle; clear timeout counter; go to CRC_WAIT.
- CRC_WAIT:
  - crc_done=1 latches crc_calc, sets byte_idx=0 and rd_addr=0, and goes to FETCH.
  - The timeout counter reaching CRC_TIMEOUT-1 without crc_done goes to ERR.
  - crc_done seen in any other state is ignored.
- Byte order, N = 2*Q+5 bytes:
  - idx0 = SADDR
  - idx1 = func
  - idx2 = Q
  - idx 3+2k = rd_data[15:8] of word k
  - idx 4+2k = rd_data[7:0] of word k
  - idx N-2 = crc[7:0]
  - idx N-1 = crc[15:8]
- FETCH: one cycle so rd_data reflects rd_addr. At the end of FETCH, tx_byte is registered from byte_idx, tx_byte_valid is set to 1, and the state goes to SEND.
- SEND:
  - tx_byte and tx_byte_valid are held stable until tx_byte_valid & tx_byte_ready in the same cycle.
  - On acceptance: byte_idx+1 and tx_byte_valid=0 next cycle.
  - rd_addr increments after a low data byte is accepted.
  - If the accepted byte was idx N-1, go to DONE; else go to FETCH.
  - Throughput: at most one byte per 2 cycles.
- DONE: tx_done=1 one cycle; rd_addr=0; go to IDLE.
- ERR: tx_err=1 one cycle; tx_byte_valid=0; go to IDLE.
- tx_start while busy is ignored and not queued.
- Simultaneous tx_start and DONE/ERR: the new request is ignored; the requester retries after busy falls.
- Q=0: frame is 5 bytes, no data fetch, and rd_addr stays 0.
- Register-file read arbitration: rd_addr is only meaningful in FETCH/SEND. The CRC stage owns the register-file read port during CRC_WAIT; top-level muxes on busy state.
- Counter widths: byte_idx is 9 bits (max 255 bytes); the timeout counter is 16 bits.

Test Plan:
- SADDR=01, func=03, Q=2, words {0x1234, 0x5678}, CRC model returns 0xABCD 10 cycles after crc_start, ready tied 1 -> bytes 01 03 02 12 34 56 78 CD AB, then a single tx_done. crc_start is one pulse with crc_quantity=2.
- Q=0, func=06, crc=0x1F2E -> bytes 01 06 00 2E 1F, rd_addr never leaves 0, tx_done once.
- Q=2 with tx_byte_ready low for 5 cycles on every 3rd byte -> tx_byte and tx_byte_valid held stable through stalls; byte sequence identical to the first scenario.
- Q=126 (>MAX_QTY) -> no crc_start, tx_err pulse 1 cycle after tx_start, no tx_byte_valid; busy high for exactly 1 cycle.
- CRC model never asserts crc_done -> tx_err exactly CRC_TIMEOUT cycles after crc_start; an extra tx_start mid-frame is ignored.
- rst_in pulsed while sending byte idx 4 -> all outputs 0 asynchronously; a following tx_start produces a complete fresh frame starting with 01.

Source files
------------

// File: rtl/modbus_tx_framer.sv
// Modbus RTU response framer: requests the CRC, then streams
// address, function, quantity, data words and CRC over valid/ready.
module modbus_tx_framer #(
  parameter logic [7:0]  SADDR       = 8'h01,
  parameter logic [7:0]  MAX_QTY     = 8'd125,
  parameter logic [15:0] CRC_TIMEOUT = 16'd4096
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tx_start,
  input  logic [7:0]  func_code,
  input  logic [7:0]  tx_quantity,
  output logic [7:0]  crc_func_code,
  output logic [7:0]  crc_quantity,
  output logic        crc_start,
  input  logic [15:0] crc_calc,
  input  logic        crc_done,
  output logic [7:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_valid,
  input  logic        tx_byte_ready,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_err
);
  typedef enum logic [2:0] {
    S_IDLE, S_CRC_REQ, S_CRC_WAIT, S_FETCH, S_SEND, S_DONE, S_ERR
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [8:0]  r_byte_idx;
  logic [15:0] r_tmo;
  logic [15:0] r_crc;
  logic [7:0]  r_func, r_qty, r_rd_addr, r_tx_byte;
  logic        r_tx_valid;
  logic [8:0]  w_nbytes;
  logic        w_accept, w_last, w_low_data;
  logic [7:0]  w_byte;

  assign crc_func_code = r_func;
  assign crc_quantity  = r_qty;
  assign rd_addr       = r_rd_addr;
  assign tx_byte       = r_tx_byte;
  assign tx_byte_valid = r_tx_valid;

  // Q is capped at MAX_QTY before a frame starts, so 2Q+5 fits in 9 bits.
  assign w_nbytes   = {r_qty, 1'b0} + 9'd5;
  assign w_accept   = r_tx_valid & tx_byte_ready;
  assign w_last     = (r_byte_idx == w_nbytes - 9'd1);
  assign w_low_data = (r_byte_idx >= 9'd4) && (r_byte_idx < w_nbytes - 9'd2) && !r_byte_idx[0];

  always_comb begin
    w_byte = r_byte_idx[0] ? rd_data[15:8] : rd_data[7:0];
    if (r_byte_idx == 9'd0)                 w_byte = SADDR;
    else if (r_byte_idx == 9'd1)            w_byte = r_func;
    else if (r_byte_idx == 9'd2)            w_byte = r_qty;
    else if (r_byte_idx == w_nbytes - 9'd2) w_byte = r_crc[7:0];
    else if (w_last)                        w_byte = r_crc[15:8];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    crc_start   = 1'b0;
    busy        = (r_state != S_IDLE);
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    case (r_state)
      S_IDLE:     if (tx_start) w_state_nxt = (tx_quantity > MAX_QTY) ? S_ERR : S_CRC_REQ;
      S_CRC_REQ: begin
        crc_start   = 1'b1;
        w_state_nxt = S_CRC_WAIT;
      end
      S_CRC_WAIT: begin
        if (crc_done)                             w_state_nxt = S_FETCH;
        else if (r_tmo == CRC_TIMEOUT - 16'd1)    w_state_nxt = S_ERR;
      end
      S_FETCH:    w_state_nxt = S_SEND;
      S_SEND:     if (w_accept) w_state_nxt = w_last ? S_DONE : S_FETCH;
      S_DONE: begin
        tx_done     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        tx_err      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_func     <= '0;
      r_qty      <= '0;
      r_tmo      <= '0;
      r_crc      <= '0;
      r_byte_idx <= '0;
      r_rd_addr  <= '0;
      r_tx_byte  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (tx_start) begin
          r_func <= func_code;
          r_qty  <= tx_quantity;
          r_tmo  <= '0;
        end
        // The crc_start cycle counts as cycle 0 of the timeout window.
        S_CRC_REQ: r_tmo <= r_tmo + 16'd1;
        S_CRC_WAIT: begin
          r_tmo <= r_tmo + 16'd1;
          if (crc_done) begin
            r_crc      <= crc_calc;
            r_byte_idx <= '0;
            r_rd_addr  <= '0;
          end
        end
        S_FETCH: begin
          r_tx_byte  <= w_byte;
          r_tx_valid <= 1'b1;
        end
        S_SEND: if (w_accept) begin
          r_tx_valid <= 1'b0;
          r_byte_idx <= r_byte_idx + 9'd1;
          if (w_low_data) r_rd_addr <= r_rd_addr + 8'd1;
        end
        S_DONE:  r_rd_addr  <= '0;
        S_ERR:   r_tx_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_modbus_tx_framer.sv
// Directed bench for modbus_tx_framer: CRC stage and register file are
// modelled inline; expected bytes are hand-computed frame constants.
module tb_modbus_tx_framer;
  logic        clk_in = 1'b0, rst_in = 1'b1;
  logic        tx_start = 1'b0;
  logic [7:0]  func_code = '0, tx_quantity = '0;
  logic [7:0]  crc_func_code, crc_quantity;
  logic        crc_start;
  logic [15:0] crc_calc = '0;
  logic        crc_done = 1'b0;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  tx_byte;
  logic        tx_byte_valid;
  logic        tx_byte_ready = 1'b1;
  logic        busy, tx_done, tx_err;

  modbus_tx_framer dut (
    .clk_in(clk_in), .rst_in(rst_in), .tx_start(tx_start), .func_code(func_code),
    .tx_quantity(tx_quantity), .crc_func_code(crc_func_code), .crc_quantity(crc_quantity),
    .crc_start(crc_start), .crc_calc(crc_calc), .crc_done(crc_done), .rd_addr(rd_addr),
    .rd_data(rd_data), .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid),
    .tx_byte_ready(tx_byte_ready), .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk_in = ~clk_in;

  logic [15:0] mem [0:3];
  assign rd_data = (rd_addr < 8'd4) ? mem[rd_addr[1:0]] : 16'hDEAD;

  int n_chk = 0, n_fail = 0;
  logic [7:0] got [0:15];
  logic [7:0] exp1 [0:8];
  logic [7:0] exp2 [0:4];
  int nb, n_crc_start, start_cyc, err_cyc, n_done, n_err, busy_cyc, valid_cyc, max_rd;
  logic [7:0] cap_q, cap_f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] f, input logic [7:0] q, input logic [15:0] crc,
                           input int delay, input bit stall, input int rst_idx, input int xstart);
    int stop_at, stall_left;
    bit stalled, fin;
    logic [7:0] held;
    nb = 0; n_crc_start = 0; start_cyc = -1; err_cyc = -1; n_done = 0; n_err = 0;
    busy_cyc = 0; valid_cyc = 0; max_rd = 0; cap_q = '0; cap_f = '0;
    stop_at = -1; stall_left = 0; stalled = 0; fin = 0; held = '0;
    for (int i = 0; i < 16; i++) got[i] = 8'hXX;
    tx_start = 1'b1; func_code = f; tx_quantity = q;
    @(negedge clk_in);
    tx_start = 1'b0;
    for (int cyc = 1; cyc < 6000 && !fin; cyc++) begin
      if (busy) busy_cyc++;
      if (tx_byte_valid) valid_cyc++;
      if (int'(rd_addr) > max_rd) max_rd = int'(rd_addr);
      if (crc_start) begin
        n_crc_start++; start_cyc = cyc; cap_q = crc_quantity; cap_f = crc_func_code;
      end
      if (tx_done) n_done++;
      if (tx_err) begin n_err++; err_cyc = cyc; end
      if ((tx_done || tx_err) && stop_at < 0) stop_at = cyc + 3;
      crc_done = (delay >= 0 && start_cyc >= 0 && cyc == start_cyc + delay);
      crc_calc = crc;
      tx_start = (cyc == xstart);
      tx_byte_ready = 1'b1;
      if (tx_byte_valid) begin
        if (rst_idx == nb) begin
          rst_in = 1'b1;
          #1;
          check("rst_valid", tx_byte_valid, 0);
          check("rst_byte", tx_byte, 0);
          check("rst_busy", busy, 0);
          check("rst_rdaddr", rd_addr, 0);
          check("rst_func", crc_func_code, 0);
          check("rst_qty", crc_quantity, 0);
          check("rst_flags", {crc_start, tx_done, tx_err}, 0);
          crc_done = 1'b0;
          @(negedge clk_in);
          rst_in = 1'b0;
          return;
        end
        if (stall && !stalled && stall_left == 0 && (nb % 3) == 2) begin
          stall_left = 5; stalled = 1; held = tx_byte;
        end
        if (stall_left > 0) begin
          check("stall_valid", tx_byte_valid, 1);
          check("stall_byte", tx_byte, held);
          tx_byte_ready = 1'b0;
          stall_left--;
        end else begin
          if (nb < 16) got[nb] = tx_byte;
          nb++;
          stalled = 0;
        end
      end
      if (cyc == stop_at) fin = 1;
      @(negedge clk_in);
    end
    crc_done = 1'b0; tx_start = 1'b0; tx_byte_ready = 1'b1;
    check("frame_end_in_budget", fin, 1);
  endtask

  initial begin
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[3] = 16'hDEF0;
    exp1 = '{8'h01, 8'h03, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hCD, 8'hAB};
    exp2 = '{8'h01, 8'h06, 8'h00, 8'h2E, 8'h1F};

    #1;
    check("reset_outputs", {crc_func_code, crc_quantity, rd_addr, tx_byte}, 0);
    check("reset_flags", {crc_start, tx_byte_valid, busy, tx_done, tx_err}, 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("idle_busy", busy, 0);

    // Q=2 basic frame
    run_frame(8'h03, 8'd2, 16'hABCD, 10, 0, -1, -1);
    check("s1_nbytes", nb, 9);
    for (int i = 0; i < 9; i++) check($sformatf("s1_byte%0d", i), got[i], exp1[i]);
    check("s1_crc_start", n_crc_start, 1);
    check("s1_crc_qty", cap_q, 2);
    check("s1_crc_func", cap_f, 8'h03);
    check("s1_done", n_done, 1);
    check("s1_err", n_err, 0);
    check("s1_rdaddr_end", rd_addr, 0);

    // Q=0 frame
    run_frame(8'h06, 8'd0, 16'h1F2E, 10, 0, -1, -1);
    check("s2_nbytes", nb, 5);
    for (int i = 0; i < 5; i++) check($sformatf("s2_byte%0d", i), got[i], exp2[i]);
    check("s2_maxrd", max_rd, 0);
    check("s2_done", n_done, 1);

    // backpressure
    run_frame(8'h03, 8'd2, 16'hABCD, 10, 1, -1, -1);
    check("s3_nbytes", nb, 9);
    for (int i = 0; i < 9; i++) check($sformatf("s3_byte%0d", i), got[i], exp1[i]);
    check("s3_done", n_done, 1);

    // quantity over limit
    run_frame(8'h03, 8'd126, 16'hABCD, 10, 0, -1, -1);
    check("s4_crc_start", n_crc_start, 0);
    check("s4_err_cyc", err_cyc, 1);
    check("s4_err_cnt", n_err, 1);
    check("s4_valid_cyc", valid_cyc, 0);
    check("s4_busy_cyc", busy_cyc, 1);
    check("s4_done", n_done, 0);

    // CRC never completes, extra tx_start while busy
    run_frame(8'h03, 8'd1, 16'hABCD, -1, 0, -1, 100);
    check("s5_crc_start", n_crc_start, 1);
    check("s5_err_cnt", n_err, 1);
    check("s5_err_delay", err_cyc - start_cyc, 4096);
    check("s5_valid_cyc", valid_cyc, 0);
    check("s5_done", n_done, 0);
    check("s5_idle", busy, 0);

    // async reset while idx 4 is on the bus, then a fresh frame
    run_frame(8'h03, 8'd2, 16'hABCD, 10, 0, 4, -1);
    check("s6_partial_nb", nb, 4);
    repeat (3) begin
      check("s6_post_rst_busy", busy, 0);
      check("s6_post_rst_flags", {tx_done, tx_byte_valid}, 0);
      @(negedge clk_in);
    end
    run_frame(8'h03, 8'd2, 16'hABCD, 10, 0, -1, -1);
    check("s6_nbytes", nb, 9);
    for (int i = 0; i < 9; i++) check($sformatf("s6_byte%0d", i), got[i], exp1[i]);
    check("s6_done", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
